// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// NZCV flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_UDIV  = 4'b1001,
        OP_NOR   = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UDIV);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative engine for MUL (radix-2 shift-add) and UDIV (restoring, MSB first).
// One step per cycle for N cycles after start.
module alu_muldiv import alu_pkg::*; #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] res_o
);
    localparam int CW = $clog2(N) + 1;

    // acc: MUL accumulator / UDIV partial remainder (N+1 bits for the trial).
    // sa : MUL multiplicand / UDIV dividend shifting into quotient.
    // sb : MUL multiplier / UDIV divisor.
    logic [N:0]    acc_q, acc_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          div_q, div_d;
    logic          dz_q, dz_d;
    logic [N:0]    trial;
    logic          ge;

    always_comb begin
        acc_d = acc_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        cnt_d = cnt_q;
        run_d = run_q;
        div_d = div_q;
        dz_d  = dz_q;
        trial = {acc_q[N-1:0], sa_q[N-1]};
        ge    = (trial >= {1'b0, sb_q});
        if (start_i) begin
            acc_d = '0;
            sa_d  = a_i;
            sb_d  = b_i;
            cnt_d = CW'(N - 1);
            run_d = 1'b1;
            div_d = div_i;
            dz_d  = (b_i == '0);
        end else if (run_q) begin
            if (div_q) begin
                acc_d = ge ? (trial - {1'b0, sb_q}) : trial;
                sa_d  = {sa_q[N-2:0], ge};
            end else begin
                if (sb_q[0])
                    acc_d = {1'b0, acc_q[N-1:0] + sa_q};
                sa_d = sa_q << 1;
                sb_d = sb_q >> 1;
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // The final step and the top-level capture share an edge, so the result
    // is taken from the next-state values.
    assign done_o = run_q && (cnt_q == '0);
    assign res_o  = div_q ? (dz_q ? '0 : sa_d) : acc_d[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
            dz_q  <= dz_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready on both sides: single-cycle logic/arith
// ops plus iterative MUL and UDIV, with registered result and NZCV flags.
module alu_seq import alu_pkg::*; #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);
    alu_state_e    state_q, state_d;
    logic [N-1:0]  res_q, res_d;
    alu_flags_t    flg_q, flg_d;

    logic [N-1:0]  alu_res;
    alu_flags_t    alu_flg;
    logic [N:0]    sum, dif;
    logic          accept;
    logic          md_start, md_done;
    logic [N-1:0]  md_res;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    // Single-cycle datapath; dif[N] is the borrow out of the subtraction.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_flg = '0;
        case (ALUControl)
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_flg.c = sum[N];
                alu_flg.v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res   = dif[N-1:0];
                alu_flg.c = ~dif[N];
                alu_flg.v = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            OP_PASSB: alu_res = b;
            OP_NOR:   alu_res = ~(a | b);
            default:  alu_res = '0;
        endcase
        alu_flg.n = alu_res[N-1];
        alu_flg.z = (alu_res == '0);
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        flg_d    = flg_q;
        md_start = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_multi(ALUControl)) begin
                        md_start = 1'b1;
                        state_d  = S_BUSY;
                    end else begin
                        res_d   = alu_res;
                        flg_d   = alu_flg;
                        state_d = S_DONE;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (md_done) begin
                    res_d   = md_res;
                    flg_d.n = md_res[N-1];
                    flg_d.z = (md_res == '0);
                    flg_d.c = 1'b0;
                    flg_d.v = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    alu_muldiv #(.N(N)) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start),
        .div_i   (ALUControl == OP_UDIV),
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .res_o   (md_res)
    );

    assign result   = res_q;
    assign negative = flg_q.n;
    assign zero     = flg_q.z;
    assign carry    = flg_q.c;
    assign overflow = flg_q.v;

endmodule
